multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL declare parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Opcode  input  7  opcode field of instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory handshake; access completes in cycle sampled high.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write, i_or_d, mem_to_reg, regwrite, pc_src, each output 1 bit.
REQ-008 SHALL have outputs ALUsrcA  output  1  (0=PC, 1=rs1), ALUsrcB  output  2  (00=rs2, 01=const 4, 10=imm), ALUOp  output  2  (00 add, 01 sub, 10 funct-decoded).
REQ-009 SHALL have outputs state  output  4  current state code, illegal  output  1  sticky error, instr_done  output  1  retire pulse, instr_count  output  CNT_W  retired count.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, ERROR=9; codes 10-15 unreachable, SHALL go to ERROR if entered.
REQ-011 All outputs SHALL be combinational from state, zero, mem_ready; any signal not listed for a state is 0 (never x).
REQ-012 FETCH: mem_read=1, ALUsrcA=0, ALUsrcB=01, ALUOp=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, go DECODE when 1.
REQ-013 DECODE: ALUsrcA=0, ALUsrcB=10, ALUOp=00; next on Opcode: 0110011->EXECUTE, 0000011 or 0100011->MEM_ADDR, 1100011->BRANCH, other->ERROR.
REQ-014 MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ALUOp=00; Opcode 0000011->MEM_READ, else MEM_WRITE.
REQ-015 MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-016 MEM_WB: regwrite=1, mem_to_reg=1; ->FETCH.
REQ-017 MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-018 EXECUTE: ALUsrcA=1, ALUsrcB=00, ALUOp=10; ->ALU_WB.
REQ-019 ALU_WB: regwrite=1, mem_to_reg=0; ->FETCH.
REQ-020 BRANCH: ALUsrcA=1, ALUsrcB=00, ALUOp=01, pc_src=1, pc_write=zero; ->FETCH regardless of zero.
REQ-021 ERROR: all control outputs 0, illegal=1; remain until reset.
REQ-022 instr_done SHALL be 1 in MEM_WB, ALU_WB, BRANCH, and MEM_WRITE with mem_ready=1; else 0.
REQ-023 instr_count SHALL increment by 1 on each clock edge where instr_done=1, wrapping from all-ones to 0.
REQ-024 Minimum latency with mem_ready tied high: R-type 4, load 5, store 4, branch 3 cycles, FETCH to FETCH.
REQ-025 mem_ready SHALL be ignored outside FETCH, MEM_READ, MEM_WRITE.

Reset
REQ-026 On a rising edge with rst_n=0: state=FETCH, instr_count=0, illegal=0, regardless of current state or pending memory access.
REQ-027 While rst_n=0, pc_write, ir_write, regwrite, mem_write SHALL be forced 0; after reset release, outputs equal FETCH decode (mem_read=1, ALUsrcB=01, others 0 except handshake terms).
REQ-028 Reset SHALL take priority over every transition, including entry into ERROR in the same cycle.

Verification
REQ-029 Reset, mem_ready=1, Opcode=0110011 -> states 0,1,6,7,0; regwrite=1 only in state 7; instr_count=1.
REQ-030 Opcode=0000011, mem_ready low 3 cycles in MEM_READ -> state 3 held 4 cycles, mem_read=1 and i_or_d=1 throughout, then 4 with mem_to_reg=1, regwrite=1.
REQ-031 Opcode=1100011 with zero=1 then zero=0 on a second branch -> pc_write=1 with pc_src=1 in first state 8, pc_write=0 in second; instr_count=2.
REQ-032 Opcode=1111111 in DECODE -> state 9, illegal=1, all write enables 0 for 10+ cycles; rst_n=0 one edge -> state 0, illegal=0.
REQ-033 rst_n=0 asserted in state 5 with mem_ready=1 -> mem_write=0 that cycle, no instr_count increment, state=0 next.
REQ-034 CNT_W=4, 16 back-to-back R-type instructions -> instr_count wraps 15->0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/handshake bundle between the multicycle control unit and its datapath.
// The control unit uses the master side; the datapath (or bench) uses slave.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       Opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             mem_to_reg;
  logic             regwrite;
  logic             pc_src;
  logic             ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [1:0]       ALUOp;
  logic [3:0]       state;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d, mem_to_reg,
           regwrite, pc_src, ALUsrcA, ALUsrcB, ALUOp, state, illegal,
           instr_done, instr_count
  );

  modport slave (
    output Opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d, mem_to_reg,
           regwrite, pc_src, ALUsrcA, ALUsrcB, ALUOp, state, illegal,
           instr_done, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: fetch/decode/memory/execute/branch
// sequencing with a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] instr_count_r;

  logic       pc_write_s, ir_write_s, mem_read_s, mem_write_s, i_or_d_s;
  logic       mem_to_reg_s, regwrite_s, pc_src_s, alu_src_a_s, illegal_s;
  logic       done_raw_s, instr_done_s;
  logic [1:0] alu_src_b_s, alu_op_s;

  // State register; reset wins over every transition, including into ERROR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count_r <= {CNT_W{1'b0}};
    end else if (instr_done_s) begin
      instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  // Next-state and per-state control decode; unlisted signals stay 0.
  always_comb begin
    state_nxt_s  = state_r;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    i_or_d_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    regwrite_s   = 1'b0;
    pc_src_s     = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    illegal_s    = 1'b0;
    done_raw_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
        state_nxt_s = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_s = 2'b10;
        case (bus.Opcode)
          OP_RTYPE:  state_nxt_s = S_EXECUTE;
          OP_LOAD:   state_nxt_s = S_MEM_ADDR;
          OP_STORE:  state_nxt_s = S_MEM_ADDR;
          OP_BRANCH: state_nxt_s = S_BRANCH;
          default:   state_nxt_s = S_ERROR;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        state_nxt_s = (bus.Opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_s  = 1'b1;
        i_or_d_s    = 1'b1;
        state_nxt_s = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        regwrite_s   = 1'b1;
        mem_to_reg_s = 1'b1;
        done_raw_s   = 1'b1;
        state_nxt_s  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        done_raw_s  = bus.mem_ready;
        state_nxt_s = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_nxt_s = S_ALU_WB;
      end
      S_ALU_WB: begin
        regwrite_s  = 1'b1;
        done_raw_s  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b01;
        pc_src_s    = 1'b1;
        pc_write_s  = bus.zero;
        done_raw_s  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_ERROR: begin
        illegal_s   = 1'b1;
        state_nxt_s = S_ERROR;
      end
      default: begin
        state_nxt_s = S_ERROR;
      end
    endcase
  end

  // Architectural side effects are suppressed while reset is held.
  assign instr_done_s    = done_raw_s & rst_n;
  assign bus.pc_write    = pc_write_s & rst_n;
  assign bus.ir_write    = ir_write_s & rst_n;
  assign bus.regwrite    = regwrite_s & rst_n;
  assign bus.mem_write   = mem_write_s & rst_n;
  assign bus.mem_read    = mem_read_s;
  assign bus.i_or_d      = i_or_d_s;
  assign bus.mem_to_reg  = mem_to_reg_s;
  assign bus.pc_src      = pc_src_s;
  assign bus.ALUsrcA     = alu_src_a_s;
  assign bus.ALUsrcB     = alu_src_b_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.illegal     = illegal_s;
  assign bus.instr_done  = instr_done_s;
  assign bus.state       = state_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit with a small counter width so
// the retired-count wrap is reachable.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {pc_write, ir_write, mem_read, mem_write, i_or_d, mem_to_reg, regwrite,
  //  pc_src, ALUsrcA, ALUsrcB[1:0], ALUOp[1:0], illegal, instr_done}
  localparam logic [14:0] PCW  = 15'h4000;
  localparam logic [14:0] IRW  = 15'h2000;
  localparam logic [14:0] MRD  = 15'h1000;
  localparam logic [14:0] MWR  = 15'h0800;
  localparam logic [14:0] IORD = 15'h0400;
  localparam logic [14:0] M2R  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] PCS  = 15'h0080;
  localparam logic [14:0] SA   = 15'h0040;
  localparam logic [14:0] SB4  = 15'h0010;
  localparam logic [14:0] SBI  = 15'h0020;
  localparam logic [14:0] AOS  = 15'h0004;
  localparam logic [14:0] AOF  = 15'h0008;
  localparam logic [14:0] ILL  = 15'h0002;
  localparam logic [14:0] DONE = 15'h0001;
  localparam logic [14:0] F_OK   = PCW | IRW | MRD | SB4;
  localparam logic [14:0] F_WAIT = MRD | SB4;

  typedef struct {
    logic          rst;
    logic [6:0]    opc;
    logic          z;
    logic          m;
    logic [3:0]    st;
    logic [14:0]   ctl;
    logic [CW-1:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  vec_t vecs[$];
  vec_t sb[$];
  int   applied;
  int   miscompares;

  multicycle_control_unit_if #(.CNT_W(CW)) bus ();

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [6:0] o, input logic z,
                     input logic m, input logic [3:0] s, input logic [14:0] c,
                     input logic [CW-1:0] n);
    vec_t v;
    v.rst = r; v.opc = o; v.z = z; v.m = m; v.st = s; v.ctl = c; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    add(1'b0, RT, 1'b0, 1'b1, 4'd0, F_WAIT, 4'd0);
    // R-type: 0,1,6,7
    add(1'b1, RT, 1'b0, 1'b1, 4'd0, F_OK, 4'd0);
    add(1'b1, RT, 1'b0, 1'b1, 4'd1, SBI, 4'd0);
    add(1'b1, RT, 1'b0, 1'b1, 4'd6, SA | AOF, 4'd0);
    add(1'b1, RT, 1'b0, 1'b1, 4'd7, RW | DONE, 4'd0);
    // load with three wait cycles in MEM_READ
    add(1'b1, LD, 1'b0, 1'b1, 4'd0, F_OK, 4'd1);
    add(1'b1, LD, 1'b0, 1'b1, 4'd1, SBI, 4'd1);
    add(1'b1, LD, 1'b0, 1'b1, 4'd2, SA | SBI, 4'd1);
    for (int i = 0; i < 3; i++) add(1'b1, LD, 1'b0, 1'b0, 4'd3, MRD | IORD, 4'd1);
    add(1'b1, LD, 1'b0, 1'b1, 4'd3, MRD | IORD, 4'd1);
    add(1'b1, LD, 1'b0, 1'b1, 4'd4, RW | M2R | DONE, 4'd1);
    // store with a fetch stall and one write wait
    add(1'b1, ST, 1'b0, 1'b0, 4'd0, F_WAIT, 4'd2);
    add(1'b1, ST, 1'b0, 1'b1, 4'd0, F_OK, 4'd2);
    add(1'b1, ST, 1'b0, 1'b1, 4'd1, SBI, 4'd2);
    add(1'b1, ST, 1'b0, 1'b1, 4'd2, SA | SBI, 4'd2);
    add(1'b1, ST, 1'b0, 1'b0, 4'd5, MWR | IORD, 4'd2);
    add(1'b1, ST, 1'b0, 1'b1, 4'd5, MWR | IORD | DONE, 4'd2);
    // branch taken, then not taken (mem_ready low in DECODE is ignored)
    add(1'b1, BR, 1'b1, 1'b1, 4'd0, F_OK, 4'd3);
    add(1'b1, BR, 1'b1, 1'b1, 4'd1, SBI, 4'd3);
    add(1'b1, BR, 1'b1, 1'b1, 4'd8, SA | AOS | PCS | DONE | PCW, 4'd3);
    add(1'b1, BR, 1'b0, 1'b1, 4'd0, F_OK, 4'd4);
    add(1'b1, BR, 1'b0, 1'b0, 4'd1, SBI, 4'd4);
    add(1'b1, BR, 1'b0, 1'b1, 4'd8, SA | AOS | PCS | DONE, 4'd4);
    // illegal opcode traps and stays trapped
    add(1'b1, BAD, 1'b0, 1'b1, 4'd0, F_OK, 4'd5);
    add(1'b1, BAD, 1'b0, 1'b1, 4'd1, SBI, 4'd5);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] b;
      b = 4'(i);
      add(1'b1, RT, b[1], b[0], 4'd9, ILL, 4'd5);
    end
    add(1'b0, RT, 1'b0, 1'b1, 4'd9, ILL, 4'd5);
    add(1'b1, ST, 1'b0, 1'b0, 4'd0, F_WAIT, 4'd0);
    // reset during a completing store write
    add(1'b1, ST, 1'b0, 1'b1, 4'd0, F_OK, 4'd0);
    add(1'b1, ST, 1'b0, 1'b1, 4'd1, SBI, 4'd0);
    add(1'b1, ST, 1'b0, 1'b1, 4'd2, SA | SBI, 4'd0);
    add(1'b1, ST, 1'b0, 1'b0, 4'd5, MWR | IORD, 4'd0);
    add(1'b0, ST, 1'b0, 1'b1, 4'd5, IORD, 4'd0);
    // reset beats the DECODE->ERROR transition
    add(1'b1, BAD, 1'b0, 1'b1, 4'd0, F_OK, 4'd0);
    add(1'b0, BAD, 1'b0, 1'b1, 4'd1, SBI, 4'd0);
    // 16 back-to-back R-types wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      add(1'b1, RT, 1'b0, 1'b1, 4'd0, F_OK, CW'(k));
      add(1'b1, RT, 1'b0, 1'b1, 4'd1, SBI, CW'(k));
      add(1'b1, RT, 1'b0, 1'b1, 4'd6, SA | AOF, CW'(k));
      add(1'b1, RT, 1'b0, 1'b1, 4'd7, RW | DONE, CW'(k));
    end
    add(1'b1, RT, 1'b0, 1'b1, 4'd0, F_OK, 4'd0);
  endtask

  initial begin
    vec_t e;
    logic [14:0] act;
    applied     = 0;
    miscompares = 0;
    build_table();
    rst_n         = 1'b0;
    bus.Opcode    = RT;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n         = vecs[i].rst;
      bus.Opcode    = vecs[i].opc;
      bus.zero      = vecs[i].z;
      bus.mem_ready = vecs[i].m;
      sb.push_back(vecs[i]);
      @(negedge clk);
      applied++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL vec%0d scoreboard: act=empty exp=entry", i);
      end else begin
        e = sb.pop_front();
        act = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
               bus.i_or_d, bus.mem_to_reg, bus.regwrite, bus.pc_src,
               bus.ALUsrcA, bus.ALUsrcB, bus.ALUOp, bus.illegal, bus.instr_done};
        if (bus.state !== e.st) begin
          miscompares++;
          $display("FAIL vec%0d state: act=%0d exp=%0d", i, bus.state, e.st);
        end
        if (act !== e.ctl) begin
          miscompares++;
          $display("FAIL vec%0d ctl: act=%015b exp=%015b", i, act, e.ctl);
        end
        if (bus.instr_count !== e.cnt) begin
          miscompares++;
          $display("FAIL vec%0d count: act=%0d exp=%0d", i, bus.instr_count, e.cnt);
        end
      end
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
